regfile_mp_sb: RTL and testbench



---
 rtl/regfile_mp_sb.sv | 98 +++++++++
 tb/tb_regfile_mp_sb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write ports, same-cycle write-to-read bypass
// and a per-register busy scoreboard for RAW/WAW hazard detection at issue.
module regfile_mp_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic                     alloc_stall
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  generate
    if (NUM_RD < 1 || NUM_RD > 8) begin : gBadNumRd
      $error("regfile_mp_sb: NUM_RD must be in 1..8");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic [DEPTH-1:0]  writeHit;
  logic              wr0Take;
  logic              wr1Take;
  logic              allocZero;
  logic              allocBlocked;
  logic              allocTake;

  // writeHit marks every address written this cycle, including r0, since any
  // enabled write clears busy and makes the register's data valid via bypass.
  always_comb begin
    writeHit = '0;
    if (wr0_en) writeHit[wr0_addr] = 1'b1;
    if (wr1_en) writeHit[wr1_addr] = 1'b1;
  end

  always_comb begin
    wr0Take      = wr0_en && !(HAS_ZERO && wr0_addr == '0);
    wr1Take      = wr1_en && !(HAS_ZERO && wr1_addr == '0);
    allocZero    = HAS_ZERO && alloc_addr == '0;
    allocBlocked = alloc_en && !allocZero && busy[alloc_addr] && !writeHit[alloc_addr];
    allocTake    = alloc_en && !allocZero && !allocBlocked;
  end

  assign alloc_stall = !rst && allocBlocked;

  // Clear first, then set, so a fresh allocation outranks a same-cycle writeback.
  always_comb begin
    busyNext = busy & ~writeHit;
    if (allocTake) busyNext[alloc_addr] = 1'b1;
    if (HAS_ZERO) busyNext[0] = 1'b0;
  end

  // Port 1 is applied last so it wins when both ports hit the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      busy <= '0;
    end else begin
      if (wr0Take) mem[wr0_addr] <= wr0_data;
      if (wr1Take) mem[wr1_addr] <= wr1_data;
      busy <= busyNext;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      if (rst || (HAS_ZERO && addr == '0)) data = '0;
      else if (wr1_en && wr1_addr == addr) data = wr1_data;
      else if (wr0_en && wr0_addr == addr) data = wr0_data;
      else data = mem[addr];
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_busy[i] = !rst && busy[addr] && !writeHit[addr];
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: directed scenarios plus randomized traffic checked
// every cycle against an array-based reference model; a wide 64-bit instance too.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;
  logic [1:0]  rdBusy;
  logic        wr0En;
  logic [4:0]  wr0Addr;
  logic [31:0] wr0Data;
  logic        wr1En;
  logic [4:0]  wr1Addr;
  logic [31:0] wr1Data;
  logic        allocEn;
  logic [4:0]  allocAddr;
  logic        allocStall;

  logic         wRst;
  logic [15:0]  wRdAddr;
  logic [255:0] wRdData;
  logic [3:0]   wRdBusy;
  logic         wWr0En;
  logic [3:0]   wWr0Addr;
  logic [63:0]  wWr0Data;
  logic         wWr1En;
  logic [3:0]   wWr1Addr;
  logic [63:0]  wWr1Data;
  logic         wAllocEn;
  logic [3:0]   wAllocAddr;
  logic         wAllocStall;

  int testsRun  = 0;
  int failCount = 0;
  logic checkEn = 1'b0;

  logic [31:0] modelMem [32];
  logic [31:0] modelBusy;

  regfile_mp_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .alloc_en(allocEn), .alloc_addr(allocAddr), .alloc_stall(allocStall)
  );

  regfile_mp_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(0)) dutWide (
    .clk(clk), .rst(wRst),
    .rd_addr(wRdAddr), .rd_data(wRdData), .rd_busy(wRdBusy),
    .wr0_en(wWr0En), .wr0_addr(wWr0Addr), .wr0_data(wWr0Data),
    .wr1_en(wWr1En), .wr1_addr(wWr1Addr), .wr1_data(wWr1Data),
    .alloc_en(wAllocEn), .alloc_addr(wAllocAddr), .alloc_stall(wAllocStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: outputs derived straight from the rules on register state.
  function automatic logic writtenNow(input logic [4:0] a);
    return (wr0En && wr0Addr == a) || (wr1En && wr1Addr == a);
  endfunction

  function automatic logic [31:0] expData(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (wr1En && wr1Addr == a) return wr1Data;
    if (wr0En && wr0Addr == a) return wr0Data;
    return modelMem[a];
  endfunction

  function automatic logic expBusy(input logic [4:0] a);
    if (rst) return 1'b0;
    return modelBusy[a] && !writtenNow(a);
  endfunction

  function automatic logic expStall();
    if (rst) return 1'b0;
    return allocEn && allocAddr != 5'd0 && modelBusy[allocAddr] && !writtenNow(allocAddr);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) modelMem[k] <= 32'h0;
      modelBusy <= 32'h0;
    end else begin
      if (wr0En && wr0Addr != 5'd0) modelMem[wr0Addr] <= wr0Data;
      if (wr1En && wr1Addr != 5'd0) modelMem[wr1Addr] <= wr1Data;
      if (wr0En) modelBusy[wr0Addr] <= 1'b0;
      if (wr1En) modelBusy[wr1Addr] <= 1'b0;
      if (allocEn && allocAddr != 5'd0 && !expStall()) modelBusy[allocAddr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("model rd_data[%0d]", p), {32'h0, rdData[p*32 +: 32]},
                    {32'h0, expData(rdAddr[p*5 +: 5])});
        checkOutput($sformatf("model rd_busy[%0d]", p), {63'h0, rdBusy[p]},
                    {63'h0, expBusy(rdAddr[p*5 +: 5])});
      end
      checkOutput("model alloc_stall", {63'h0, allocStall}, {63'h0, expStall()});
    end
  end

  task automatic applyStimulus(input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                               input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                               input logic ae, input logic [4:0] aa,
                               input logic [4:0] r0, input logic [4:0] r1);
    wr0En = w0e; wr0Addr = w0a; wr0Data = w0d;
    wr1En = w1e; wr1Addr = w1a; wr1Data = w1d;
    allocEn = ae; allocAddr = aa;
    rdAddr = {r1, r0};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] wPattern(input int r);
    logic [31:0] r32;
    r32 = r;
    return {32'hC0DE0000 | r32, 32'h13579BDF ^ (r32 * 32'h01010101)};
  endfunction

  initial begin
    rst = 1'b1;
    wRst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wRdAddr = '0; wWr0En = 0; wWr0Addr = '0; wWr0Data = '0;
    wWr1En = 0; wWr1Addr = '0; wWr1Data = '0; wAllocEn = 0; wAllocAddr = '0;

    nextCycle();
    checkEn = 1'b1;
    // Bypass must be suppressed while reset is held.
    applyStimulus(1, 5, 32'hAB, 0, 0, 0, 1, 6, 5, 6);
    #2;
    checkOutput("reset rd_data0", {32'h0, rdData[31:0]}, 64'h0);
    checkOutput("reset rd_busy", {62'h0, rdBusy}, 64'h0);
    checkOutput("reset alloc_stall", {63'h0, allocStall}, 64'h0);
    nextCycle();
    rst = 1'b0;
    wRst = 1'b0;

    // Async reset clears a written register mid-cycle.
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 5, 5);
    #2;
    checkOutput("bypass r5", {32'h0, rdData[31:0]}, 64'hDEADBEEF);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 5);
    #1;
    checkOutput("mem r5", {32'h0, rdData[31:0]}, 64'hDEADBEEF);
    checkOutput("busy r5 before reset", {63'h0, rdBusy[0]}, 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("async reset r5", {32'h0, rdData[31:0]}, 64'h0);
    checkOutput("async reset busy", {62'h0, rdBusy}, 64'h0);
    nextCycle();
    rst = 1'b0;
    #2;
    checkOutput("after reset r5", {32'h0, rdData[31:0]}, 64'h0);
    nextCycle();

    // Port 1 beats port 0 on the same address.
    applyStimulus(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 7);
    #2;
    checkOutput("priority bypass r7", {32'h0, rdData[31:0]}, 64'h22);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    #2;
    checkOutput("priority mem r7", {32'h0, rdData[63:32]}, 64'h22);
    nextCycle();

    applyStimulus(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
    #2;
    checkOutput("zero reg data", rdData, 64'h0);
    checkOutput("zero reg busy", {62'h0, rdBusy}, 64'h0);
    checkOutput("zero reg stall", {63'h0, allocStall}, 64'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("zero reg data next", rdData, 64'h0);
    checkOutput("zero reg busy next", {62'h0, rdBusy}, 64'h0);
    nextCycle();

    // Scoreboard on r3: allocate, stall a second allocation, clear by writeback.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
    #2;
    checkOutput("sb first alloc stall", {63'h0, allocStall}, 64'h0);
    checkOutput("sb busy before", {63'h0, rdBusy[0]}, 64'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3, 3, 3);
    #2;
    checkOutput("sb busy r3", {63'h0, rdBusy[0]}, 64'h1);
    checkOutput("sb WAW stall", {63'h0, allocStall}, 64'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 3, 32'h55, 0, 0, 3, 3);
    #2;
    checkOutput("sb writeback busy", {63'h0, rdBusy[1]}, 64'h0);
    checkOutput("sb writeback data", {32'h0, rdData[31:0]}, 64'h55);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3, 3);
    #2;
    checkOutput("sb cleared busy", {62'h0, rdBusy}, 64'h0);
    nextCycle();

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 9, 9);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 9);
    #2;
    checkOutput("alloc+wb stall r9", {63'h0, allocStall}, 64'h0);
    checkOutput("alloc+wb data r9", {32'h0, rdData[31:0]}, 64'h99);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    #2;
    checkOutput("alloc+wb busy r9", {63'h0, rdBusy[0]}, 64'h1);
    checkOutput("alloc+wb mem r9", {32'h0, rdData[31:0]}, 64'h99);
    nextCycle();

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 600; n++) begin
      logic wide;
      wide = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, wide ? 31 : 7)), $urandom,
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, wide ? 31 : 7)), $urandom,
                    1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, wide ? 31 : 7)),
                    5'($urandom_range(0, wide ? 31 : 7)), 5'($urandom_range(0, 7)));
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 64-bit, 16-deep, 4-read-port instance.
    for (int r = 0; r < 16; r += 2) begin
      wWr0En = 1'b1; wWr0Addr = 4'(r);     wWr0Data = wPattern(r);
      wWr1En = 1'b1; wWr1Addr = 4'(r + 1); wWr1Data = wPattern(r + 1);
      nextCycle();
    end
    wWr0En = 1'b0;
    wWr1En = 1'b0;
    for (int rot = 0; rot < 16; rot++) begin
      for (int p = 0; p < 4; p++) wRdAddr[p*4 +: 4] = 4'((rot + p) % 16);
      #2;
      for (int p = 0; p < 4; p++)
        checkOutput($sformatf("wide port%0d r%0d", p, (rot + p) % 16),
                    wRdData[p*64 +: 64], wPattern((rot + p) % 16));
      checkOutput("wide busy", {60'h0, wRdBusy}, 64'h0);
      nextCycle();
    end

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
